trap_entry_sequencer: RTL and testbench
=======================================

// Module: trap_entry_sequencer
// PURPOSE
//  Downstream of the exception priority encoder. Takes the single winning trap and runs machine-mode trap entry:
//  - drains the pipeline
//  - commits mepc/mcause/mtval
//  - updates mstatus MIE/MPIE
//  - issues the redirect PC from mtvec (direct or vectored)
//  Also sequences mret (return to mepc). Sole owner of the architectural mstatus interrupt bits.
// PARAMETERS
//  XLEN           32  datapath/CSR width
//  FLUSH_TIMEOUT  16  max cycles in FLUSH waiting for flush_done_in; counter width $clog2(FLUSH_TIMEOUT+1)
// PORTS
//  clk_in              in   1     clock, rising edge
//  rst_in              in   1     asynchronous, active-high reset
//  except_flag_in      in   1     encoder has a trap pending; held until acked
//  mcause_in           in   XLEN  cause; bit XLEN-1 = interrupt
//  mepc_in             in   XLEN  faulting/interrupted PC
//  mtval_in            in   XLEN  trap value
//  mtvec_in            in   XLEN  {BASE[XLEN-1:2], MODE[1:0]}
//  except_ack_out      out  1     1-cycle pulse: trap accepted, inputs latched
//  mret_in             in   1     1-cycle pulse: mret retired
//  mstatus_we_in       in   1     software CSR write to mstatus
//  mstatus_wdata_in    in   XLEN  write data (only bits 3, 7 used)
//  flush_req_out       out  1     pipeline flush request
//  flush_done_in       in   1     pipeline drained
//  csr_we_out          out  1     1-cycle strobe: commit mepc/mcause/mtval
//  mepc_out            out  XLEN  latched mepc, bits[1:0] forced 0
//  mcause_out          out  XLEN  latched mcause
//  mtval_out           out  XLEN  latched mtval
//  mstatus_out         out  XLEN  bit3 MIE, bit7 MPIE, bits12:11 MPP=2'b11, others 0
//  redirect_valid_out  out  1     redirect PC valid
//  redirect_pc_out     out  XLEN  target PC
//  redirect_ready_in   in   1     fetch accepts redirect
//  busy_out            out  1     state != IDLE
//  flush_timeout_out   out  1     sticky: a FLUSH hit FLUSH_TIMEOUT
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; all outputs 0 except mstatus_out=32'h0000_1800.
//   - latched regs and flush counter cleared; in-flight trap/redirect discarded.
//  FSM: IDLE -> FLUSH -> COMMIT -> REDIRECT -> IDLE; IDLE -> REDIRECT for mret.
//  IDLE:
//   - except_flag_in=1, accepted: latch inputs, except_ack_out=1 next cycle, flush_req_out=1, counter=0 -> FLUSH.
//   - Accepted when mcause_in[XLEN-1]=0 (exceptions always), or when interrupt and MIE=1.
//   - Interrupt with MIE=0: no ack; stay IDLE.
//   - Else mret_in=1: redirect_pc=mepc_out; MIE<=MPIE, MPIE<=1 -> REDIRECT.
//   - Accepted trap and mret same cycle: trap wins, mret dropped.
//  FLUSH:
//   - flush_req_out held 1; counter increments each cycle.
//   - flush_done_in=1 -> COMMIT.
//   - counter==FLUSH_TIMEOUT-1 without done -> set flush_timeout_out, COMMIT.
//  COMMIT (exactly 1 cycle):
//   - flush_req_out=0; csr_we_out=1 with mepc/mcause/mtval outputs valid.
//   - MPIE<=MIE, MIE<=0.
//   - redirect_pc = {BASE,2'b00} when MODE=00, MODE=1x (reserved, treated direct), or MODE=01 with non-interrupt cause.
//   - MODE=01 with interrupt: {BASE,2'b00} + (mcause[XLEN-2:0]<<2), modulo 2^XLEN.
//   - -> REDIRECT.
//  REDIRECT:
//   - redirect_valid_out=1, pc stable until redirect_ready_in=1 (that cycle = transfer).
//   - -> IDLE next cycle with valid=0.
//   - Latency from ack to redirect: >= 3 cycles.
//  Busy-state rules:
//   - except_flag_in outside IDLE: ignored, no ack (encoder holds it).
//   - mret_in outside IDLE: ignored.
//  mstatus_we_in:
//   - Honoured in any state: MIE<=wdata[3], MPIE<=wdata[7].
//   - Same cycle as a COMMIT/mret update: the trap/mret update wins.
//  Outputs mepc/mcause/mtval hold their value until the next accepted trap.
// TESTING
//  1 Exception, direct mode:
//    - mcause=2, mepc=0x0000_0106, mtvec=0x8000_0100, MIE=1.
//    - flush_done 2 cycles after ack.
//    - Expect ack pulse, csr_we with mepc_out=0x104, MIE=0, MPIE=1, redirect_pc=0x8000_0100.
//  2 Vectored interrupt:
//    - mcause=0x8000_0007, mtvec=0x8000_0101, MIE=1.
//    - Expect redirect_pc=0x8000_011C; with MIE=0, no ack and state stays IDLE.
//  3 mret after test 1 (MPIE=1):
//    - Expect redirect_pc=0x104 within 1 cycle, MIE=1, MPIE=1.
//    - Trap + mret same cycle: trap taken, mret ignored.
//  4 flush_done_in held 0:
//    - COMMIT entered exactly FLUSH_TIMEOUT cycles after FLUSH entry; flush_timeout_out=1 and stays 1.
//  5 Backpressure and busy traps:
//    - redirect_ready_in low 5 cycles: valid/pc stable.
//    - Second except_flag_in during busy: acked only after return to IDLE.
//  6 rst_in asserted in FLUSH and in REDIRECT:
//    - All outputs reset immediately, mstatus_out=0x1800; next trap runs normally.

Source files
------------

// File: rtl/trap_entry_sequencer_if.sv
// Bundle of trap, CSR, flush and redirect signals between the trap entry
// sequencer and the rest of the core.
interface trap_entry_sequencer_if #(
    parameter int XLEN = 32
);
    logic            except_flag_in;
    logic [XLEN-1:0] mcause_in;
    logic [XLEN-1:0] mepc_in;
    logic [XLEN-1:0] mtval_in;
    logic [XLEN-1:0] mtvec_in;
    logic            except_ack_out;
    logic            mret_in;
    logic            mstatus_we_in;
    logic [XLEN-1:0] mstatus_wdata_in;
    logic            flush_req_out;
    logic            flush_done_in;
    logic            csr_we_out;
    logic [XLEN-1:0] mepc_out;
    logic [XLEN-1:0] mcause_out;
    logic [XLEN-1:0] mtval_out;
    logic [XLEN-1:0] mstatus_out;
    logic            redirect_valid_out;
    logic [XLEN-1:0] redirect_pc_out;
    logic            redirect_ready_in;
    logic            busy_out;
    logic            flush_timeout_out;

    // The sequencer side.
    modport slave (
        input  except_flag_in, mcause_in, mepc_in, mtval_in, mtvec_in,
        input  mret_in, mstatus_we_in, mstatus_wdata_in,
        input  flush_done_in, redirect_ready_in,
        output except_ack_out, flush_req_out, csr_we_out,
        output mepc_out, mcause_out, mtval_out, mstatus_out,
        output redirect_valid_out, redirect_pc_out, busy_out, flush_timeout_out
    );

    // The core/encoder side driving the sequencer.
    modport master (
        output except_flag_in, mcause_in, mepc_in, mtval_in, mtvec_in,
        output mret_in, mstatus_we_in, mstatus_wdata_in,
        output flush_done_in, redirect_ready_in,
        input  except_ack_out, flush_req_out, csr_we_out,
        input  mepc_out, mcause_out, mtval_out, mstatus_out,
        input  redirect_valid_out, redirect_pc_out, busy_out, flush_timeout_out
    );
endinterface

// File: rtl/trap_entry_sequencer.sv
// Machine-mode trap entry and mret sequencer: drains the pipeline, commits
// mepc/mcause/mtval, owns mstatus MIE/MPIE and issues the redirect PC.
module trap_entry_sequencer #(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 16
) (
    input logic                   clk_in,
    input logic                   rst_in,
    trap_entry_sequencer_if.slave bus
);
    localparam int              CNT_W    = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_COMMIT,
        S_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic            timeout_q, timeout_d;
    logic            ack_q, ack_d;

    logic            trap_accept;
    logic            irq_vectored;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_target;

    // Interrupts are only taken while MIE is set; synchronous exceptions always.
    always_comb begin
        trap_accept  = bus.except_flag_in && (!bus.mcause_in[XLEN-1] || mie_q);
        tvec_base    = {mtvec_q[XLEN-1:2], 2'b00};
        irq_vectored = (mtvec_q[1:0] == 2'b01) && mcause_q[XLEN-1];
        trap_target  = irq_vectored ? tvec_base + {mcause_q[XLEN-3:0], 2'b00}
                                    : tvec_base;
    end

    always_comb begin
        // NOTE: every next-state variable gets a default before the case, so no path infers a latch.
        state_d       = state_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mtvec_d       = mtvec_q;
        redirect_pc_d = redirect_pc_q;
        cnt_d         = cnt_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        timeout_d     = timeout_q;
        ack_d         = 1'b0;

        // Software write first so the COMMIT/mret updates below override it.
        if (bus.mstatus_we_in) begin
            mie_d  = bus.mstatus_wdata_in[3];
            mpie_d = bus.mstatus_wdata_in[7];
        end

        unique case (state_q)
            S_IDLE: begin
                if (trap_accept) begin
                    mepc_d   = {bus.mepc_in[XLEN-1:2], 2'b00};
                    mcause_d = bus.mcause_in;
                    mtval_d  = bus.mtval_in;
                    mtvec_d  = bus.mtvec_in;
                    ack_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_FLUSH;
                end else if (bus.mret_in) begin
                    redirect_pc_d = mepc_q;
                    mie_d         = mpie_q;
                    mpie_d        = 1'b1;
                    state_d       = S_REDIRECT;
                end
            end
            S_FLUSH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.flush_done_in) begin
                    state_d = S_COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_COMMIT;
                end
            end
            S_COMMIT: begin
                mpie_d        = mie_q;
                mie_d         = 1'b0;
                redirect_pc_d = trap_target;
                state_d       = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.redirect_ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all architectural registers are plain flops (no arrays), so each one takes the async reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mtvec_q       <= '0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            timeout_q     <= 1'b0;
            ack_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q       <= state_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mtvec_q       <= mtvec_d;
            redirect_pc_q <= redirect_pc_d;
            cnt_q         <= cnt_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            timeout_q     <= timeout_d;
            ack_q         <= ack_d;
        end
    end

    assign bus.except_ack_out     = ack_q;
    assign bus.flush_req_out      = (state_q == S_FLUSH);
    assign bus.csr_we_out         = (state_q == S_COMMIT);
    assign bus.mepc_out           = mepc_q;
    assign bus.mcause_out         = mcause_q;
    assign bus.mtval_out          = mtval_q;
    // MPP is hardwired to machine mode.
    assign bus.mstatus_out        = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie_q,
                                     3'b000, mie_q, 3'b000};
    assign bus.redirect_valid_out = (state_q == S_REDIRECT);
    assign bus.redirect_pc_out    = redirect_pc_q;
    assign bus.busy_out           = (state_q != S_IDLE);
    assign bus.flush_timeout_out  = timeout_q;

    logic unused_bits;
    assign unused_bits = ^{bus.mepc_in[1:0], bus.mstatus_wdata_in[XLEN-1:8],
                           bus.mstatus_wdata_in[6:4], bus.mstatus_wdata_in[2:0]};
endmodule

// File: tb/tb_trap_entry_sequencer.sv
// Directed bench for trap_entry_sequencer: trap entry, vectoring, mret,
// flush timeout, backpressure, busy traps and asynchronous reset.
module tb_trap_entry_sequencer;
    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n;

    trap_entry_sequencer_if #(.XLEN(XLEN)) bus ();

    trap_entry_sequencer #(
        .XLEN          (XLEN),
        .FLUSH_TIMEOUT (16)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic raise_trap(input logic [31:0] cause, input logic [31:0] epc,
                              input logic [31:0] tval, input logic [31:0] tvec);
        bus.except_flag_in = 1'b1;
        bus.mcause_in      = cause;
        bus.mepc_in        = epc;
        bus.mtval_in       = tval;
        bus.mtvec_in       = tvec;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.except_flag_in    = 1'b0;
        bus.mcause_in         = '0;
        bus.mepc_in           = '0;
        bus.mtval_in          = '0;
        bus.mtvec_in          = '0;
        bus.mret_in           = 1'b0;
        bus.mstatus_we_in     = 1'b0;
        bus.mstatus_wdata_in  = '0;
        bus.flush_done_in     = 1'b0;
        bus.redirect_ready_in = 1'b0;
        step();
        step();
        check("rst_mstatus", bus.mstatus_out, 32'h0000_1800);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_ack", 32'(bus.except_ack_out), 32'd0);
        check("rst_flush_req", 32'(bus.flush_req_out), 32'd0);
        check("rst_redir_valid", 32'(bus.redirect_valid_out), 32'd0);
        check("rst_timeout", 32'(bus.flush_timeout_out), 32'd0);
        rst = 1'b0;
        step();

        // Software sets MIE.
        bus.mstatus_we_in    = 1'b1;
        bus.mstatus_wdata_in = 32'h0000_0008;
        step();
        bus.mstatus_we_in    = 1'b0;
        check("sw_mie_set", bus.mstatus_out, 32'h0000_1808);

        // 1: exception, direct mode.
        raise_trap(32'd2, 32'h0000_0106, 32'h0000_DEAD, 32'h8000_0100);
        step();
        bus.except_flag_in = 1'b0;
        check("t1_ack", 32'(bus.except_ack_out), 32'd1);
        check("t1_flush_req", 32'(bus.flush_req_out), 32'd1);
        step();
        check("t1_ack_pulse", 32'(bus.except_ack_out), 32'd0);
        step();
        bus.flush_done_in = 1'b1;
        step();
        bus.flush_done_in = 1'b0;
        check("t1_csr_we", 32'(bus.csr_we_out), 32'd1);
        check("t1_flush_req_low", 32'(bus.flush_req_out), 32'd0);
        check("t1_mepc", bus.mepc_out, 32'h0000_0104);
        check("t1_mcause", bus.mcause_out, 32'd2);
        check("t1_mtval", bus.mtval_out, 32'h0000_DEAD);
        step();
        check("t1_csr_we_pulse", 32'(bus.csr_we_out), 32'd0);
        check("t1_mstatus", bus.mstatus_out, 32'h0000_1880);
        check("t1_redir_valid", 32'(bus.redirect_valid_out), 32'd1);
        check("t1_redir_pc", bus.redirect_pc_out, 32'h8000_0100);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;
        check("t1_back_idle", 32'(bus.busy_out), 32'd0);
        check("t1_valid_drop", 32'(bus.redirect_valid_out), 32'd0);

        // 3: mret returns to mepc and restores MIE from MPIE.
        bus.mret_in = 1'b1;
        step();
        bus.mret_in = 1'b0;
        check("t3_mret_valid", 32'(bus.redirect_valid_out), 32'd1);
        check("t3_mret_pc", bus.redirect_pc_out, 32'h0000_0104);
        check("t3_mret_mstatus", bus.mstatus_out, 32'h0000_1888);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;

        // 2: vectored interrupt with MIE=1.
        raise_trap(32'h8000_0007, 32'h0000_0200, 32'd0, 32'h8000_0101);
        step();
        bus.except_flag_in = 1'b0;
        check("t2_ack", 32'(bus.except_ack_out), 32'd1);
        bus.flush_done_in = 1'b1;
        step();
        bus.flush_done_in = 1'b0;
        check("t2_mcause", bus.mcause_out, 32'h8000_0007);
        step();
        check("t2_redir_pc", bus.redirect_pc_out, 32'h8000_011C);
        check("t2_mstatus", bus.mstatus_out, 32'h0000_1880);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;

        // 2b: interrupt masked by MIE=0 is never acknowledged.
        raise_trap(32'h8000_0007, 32'h0000_0204, 32'd0, 32'h8000_0101);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_masked_ack", 32'(bus.except_ack_out), 32'd0);
            check("t2_masked_idle", 32'(bus.busy_out), 32'd0);
        end
        bus.except_flag_in = 1'b0;

        // 3b: trap and mret together; trap wins, mret has no effect.
        raise_trap(32'd5, 32'h0000_0300, 32'd0, 32'h0000_1000);
        bus.mret_in = 1'b1;
        step();
        bus.except_flag_in = 1'b0;
        bus.mret_in        = 1'b0;
        check("t3b_ack", 32'(bus.except_ack_out), 32'd1);
        check("t3b_no_redirect", 32'(bus.redirect_valid_out), 32'd0);
        check("t3b_mstatus_kept", bus.mstatus_out, 32'h0000_1880);
        bus.flush_done_in = 1'b1;
        step();
        bus.flush_done_in = 1'b0;
        check("t3b_mepc", bus.mepc_out, 32'h0000_0300);
        step();
        check("t3b_redir_pc", bus.redirect_pc_out, 32'h0000_1000);
        check("t3b_mstatus", bus.mstatus_out, 32'h0000_1800);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;

        // 4: flush never completes; timeout forces COMMIT after 16 cycles.
        raise_trap(32'd1, 32'h0000_0400, 32'd0, 32'h0000_2000);
        step();
        bus.except_flag_in = 1'b0;
        check("t4_timeout_clear", 32'(bus.flush_timeout_out), 32'd0);
        n = 0;
        while (!bus.csr_we_out && n < 40) begin
            step();
            n = n + 1;
        end
        check("t4_commit_latency", 32'(n), 32'd16);
        check("t4_timeout_set", 32'(bus.flush_timeout_out), 32'd1);
        step();

        // 5: redirect backpressure with a second trap and an mret while busy.
        raise_trap(32'd3, 32'h0000_0500, 32'h0000_0055, 32'h0000_3000);
        bus.mret_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.mret_in = 1'b0;
            check("t5_valid_stable", 32'(bus.redirect_valid_out), 32'd1);
            check("t5_pc_stable", bus.redirect_pc_out, 32'h0000_2000);
            check("t5_busy_no_ack", 32'(bus.except_ack_out), 32'd0);
        end
        check("t5_mret_ignored", bus.mstatus_out, 32'h0000_1800);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;
        check("t5_idle_no_ack", 32'(bus.except_ack_out), 32'd0);
        step();
        bus.except_flag_in = 1'b0;
        check("t5_late_ack", 32'(bus.except_ack_out), 32'd1);
        check("t5_timeout_sticky", 32'(bus.flush_timeout_out), 32'd1);
        bus.mstatus_we_in    = 1'b1;
        bus.mstatus_wdata_in = 32'h0000_0008;
        step();
        bus.mstatus_we_in = 1'b0;
        check("t5_sw_write_busy", bus.mstatus_out, 32'h0000_1808);
        bus.flush_done_in = 1'b1;
        step();
        bus.flush_done_in    = 1'b0;
        check("t5_mepc", bus.mepc_out, 32'h0000_0500);
        bus.mstatus_we_in    = 1'b1;
        bus.mstatus_wdata_in = 32'h0000_0088;
        step();
        bus.mstatus_we_in = 1'b0;
        check("t5_commit_beats_sw", bus.mstatus_out, 32'h0000_1880);
        check("t5_redir_pc", bus.redirect_pc_out, 32'h0000_3000);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;

        // 6: asynchronous reset in FLUSH.
        raise_trap(32'd2, 32'h0000_0600, 32'd0, 32'h0000_4000);
        step();
        bus.except_flag_in = 1'b0;
        check("t6_in_flush", 32'(bus.flush_req_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_flush_rst_busy", 32'(bus.busy_out), 32'd0);
        check("t6_flush_rst_req", 32'(bus.flush_req_out), 32'd0);
        check("t6_flush_rst_mstatus", bus.mstatus_out, 32'h0000_1800);
        check("t6_flush_rst_mepc", bus.mepc_out, 32'd0);
        check("t6_flush_rst_timeout", 32'(bus.flush_timeout_out), 32'd0);
        step();
        rst = 1'b0;

        // 6b: asynchronous reset in REDIRECT.
        raise_trap(32'd6, 32'h0000_0610, 32'd0, 32'h0000_4400);
        step();
        bus.except_flag_in = 1'b0;
        bus.flush_done_in  = 1'b1;
        step();
        bus.flush_done_in  = 1'b0;
        step();
        check("t6_in_redirect", 32'(bus.redirect_valid_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_redir_rst_valid", 32'(bus.redirect_valid_out), 32'd0);
        check("t6_redir_rst_pc", bus.redirect_pc_out, 32'd0);
        check("t6_redir_rst_mcause", bus.mcause_out, 32'd0);
        step();
        rst = 1'b0;

        // 6c: normal trap after reset.
        raise_trap(32'd4, 32'h0000_0700, 32'd0, 32'h0000_5000);
        step();
        bus.except_flag_in = 1'b0;
        check("t6_post_ack", 32'(bus.except_ack_out), 32'd1);
        bus.flush_done_in = 1'b1;
        step();
        bus.flush_done_in = 1'b0;
        check("t6_post_mepc", bus.mepc_out, 32'h0000_0700);
        step();
        check("t6_post_pc", bus.redirect_pc_out, 32'h0000_5000);
        check("t6_post_mstatus", bus.mstatus_out, 32'h0000_1800);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;

        // Reserved MODE=1x with an interrupt vectors as direct.
        bus.mstatus_we_in    = 1'b1;
        bus.mstatus_wdata_in = 32'h0000_0008;
        step();
        bus.mstatus_we_in = 1'b0;
        raise_trap(32'h8000_0003, 32'h0000_0800, 32'd0, 32'h0000_6002);
        step();
        bus.except_flag_in = 1'b0;
        bus.flush_done_in  = 1'b1;
        step();
        bus.flush_done_in  = 1'b0;
        step();
        check("mode_rsvd_pc", bus.redirect_pc_out, 32'h0000_6000);
        bus.redirect_ready_in = 1'b1;
        step();
        bus.redirect_ready_in = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
